// File: rtl/alu_stage_16.sv
// alu_stage_16 -- registered Hack ALU stage with a 2-entry result buffer.
//
// Purpose:
//   Accepts one {x, y, ctl} word per cycle through a valid/ready input port.
//   It computes the Hack ALU result and its zr/ng flags (and optionally ovf)
//   combinationally. It stores them together in a 2-entry FIFO and presents
//   the oldest entry on a valid/ready output port.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
//   A producer holds valid and its payload until the transfer. The consumer
//   sees out/zr/ng/ovf stable while out_valid && !out_ready. in_ready does
//   not depend on out_ready; full throughput comes from the second entry,
//   not from a bypass path.
//
// Configuration:
//   ALU_STAGE_OVF_EN -- when defined, adds the ovf output and per-entry
//   overflow storage. When undefined, that port and storage are absent.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   operand/control word presented
//   in_ready   out  stage can accept a word this cycle
//   x, y       in   WIDTH-bit operands
//   ctl        in   {zx,nx,zy,ny,f,no}, zx is bit 5
//   out_valid  out  result word available
//   out_ready  in   consumer accepts the result this cycle
//   out        out  WIDTH-bit result
//   zr         out  result == 0
//   ng         out  result MSB
//   ovf        out  signed overflow of the add (ALU_STAGE_OVF_EN only)
//   buf_state  out  buffer FSM state (0 EMPTY, 1 ONE, 2 TWO) for observation

module alu_stage_16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [5:0]       ctl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng,
`ifdef ALU_STAGE_OVF_EN
   output logic             ovf,
`endif
   output logic [1:0]       buf_state
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // ---------------------------------------------------------------
   // ALU datapath (combinational, feeds only the buffer write port)
   // ---------------------------------------------------------------
   logic [WIDTH-1:0] x_z;
   logic [WIDTH-1:0] x_n;
   logic [WIDTH-1:0] y_z;
   logic [WIDTH-1:0] y_n;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] f_res;
   logic [WIDTH-1:0] res;
   logic             res_zr;
   logic             res_ng;

   always_comb begin
      x_z    = ctl[5] ? '0 : x;
      x_n    = ctl[4] ? ~x_z : x_z;
      y_z    = ctl[3] ? '0 : y;
      y_n    = ctl[2] ? ~y_z : y_z;
      sum    = x_n + y_n;
      f_res  = ctl[1] ? sum : (x_n & y_n);
      res    = ctl[0] ? ~f_res : f_res;
      res_zr = (res == '0);
      res_ng = res[WIDTH-1];
   end

`ifdef ALU_STAGE_OVF_EN
   // Overflow is judged on the sum before the final 'no' inversion:
   // both operands share a sign and the sum's sign differs from it.
   logic res_ovf;

   always_comb begin
      res_ovf = ctl[1] & (x_n[WIDTH-1] == y_n[WIDTH-1]) &
                (sum[WIDTH-1] != x_n[WIDTH-1]);
   end
`endif

   // ---------------------------------------------------------------
   // Handshake qualifiers
   // ---------------------------------------------------------------
   logic push;
   logic pop;

   // in_ready is held low while reset is asserted and rises with the release.
   assign in_ready  = reset_n & (state != TWO);
   assign out_valid = (state != EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign buf_state = state;

   // ---------------------------------------------------------------
   // Buffer FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------
   // Buffer FSM: next state
   // ---------------------------------------------------------------
   always_comb begin
      state_next = state;
      unique case (state)
         EMPTY: begin
            if (push) state_next = ONE;
         end
         ONE: begin
            if (push && !pop)      state_next = TWO;
            else if (!push && pop) state_next = EMPTY;
            else                   state_next = ONE;
         end
         TWO: begin
            // push cannot occur here because in_ready is low
            if (pop) state_next = ONE;
         end
         default: state_next = EMPTY;
      endcase
   end

   // ---------------------------------------------------------------
   // Storage and 1-bit pointers (wrap modulo 2 by width)
   // ---------------------------------------------------------------
   logic [WIDTH-1:0] mem_res [2];
   logic             mem_zr  [2];
   logic             mem_ng  [2];
   logic             wr_ptr;
   logic             rd_ptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Entries are cleared on reset so the outputs read zero until the first
   // result. They also never reveal a result that was accepted before reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_res[0] <= '0;
         mem_res[1] <= '0;
         mem_zr[0]  <= 1'b0;
         mem_zr[1]  <= 1'b0;
         mem_ng[0]  <= 1'b0;
         mem_ng[1]  <= 1'b0;
      end else if (push) begin
         mem_res[wr_ptr] <= res;
         mem_zr[wr_ptr]  <= res_zr;
         mem_ng[wr_ptr]  <= res_ng;
      end
   end

`ifdef ALU_STAGE_OVF_EN
   logic mem_ovf [2];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_ovf[0] <= 1'b0;
         mem_ovf[1] <= 1'b0;
      end else if (push) begin
         mem_ovf[wr_ptr] <= res_ovf;
      end
   end

   assign ovf = mem_ovf[rd_ptr];
`endif

   // The head entry only changes on a pop. A push in state ONE writes the
   // other slot, so the outputs stay stable while the consumer stalls.
   assign out = mem_res[rd_ptr];
   assign zr  = mem_zr[rd_ptr];
   assign ng  = mem_ng[rd_ptr];

endmodule

// File: tb/tb_alu_stage_16.sv
// tb_alu_stage_16 -- self-checking bench for alu_stage_16.
// Applies a table of {x, y, ctl, expected} records and then hand-written
// sequences for back-pressure, streaming, random traffic and mid-operation
// reset. Results are compared from an expected queue as they leave the DUT.

module tb_alu_stage_16;

   localparam int W  = 16;
   localparam int EW = W + 3;   // {out, zr, ng, ovf}

   logic          clk;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  x;
   logic [W-1:0]  y;
   logic [5:0]    ctl;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out;
   logic          zr;
   logic          ng;
   logic [1:0]    buf_state;
`ifdef ALU_STAGE_OVF_EN
   logic          ovf;
`endif

   alu_stage_16 #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .ctl       (ctl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .zr        (zr),
      .ng        (ng),
`ifdef ALU_STAGE_OVF_EN
      .ovf       (ovf),
`endif
      .buf_state (buf_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int errors = 0;
   int checks = 0;
   int pops   = 0;
   logic [EW-1:0] exp_q[$];

   typedef struct {
      logic [W-1:0] vx;
      logic [W-1:0] vy;
      logic [5:0]   vctl;
      logic [W-1:0] e_out;
      logic         e_zr;
      logic         e_ng;
      logic         e_ovf;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [EW-1:0] actual_word();
`ifdef ALU_STAGE_OVF_EN
      return {out, zr, ng, ovf};
`else
      return {out, zr, ng, 1'b0};
`endif
   endfunction

   // The ovf bit of an expectation only counts when the flag is built in.
   function automatic logic [EW-1:0] mk_exp(input logic [W-1:0] o, input logic z,
                                            input logic n, input logic v);
`ifdef ALU_STAGE_OVF_EN
      return {o, z, n, v};
`else
      return {o, z, n, 1'b0 & v};
`endif
   endfunction

   // Reference model for random traffic. Overflow is derived from the carry
   // into versus out of the MSB.
   function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [5:0] c);
      logic [W-1:0] p, q, r;
      logic [W:0]   s;
      logic [W-1:0] low;
      logic         cin_msb, v;
      p = c[5] ? '0 : a;
      if (c[4]) p = ~p;
      q = c[3] ? '0 : b;
      if (c[2]) q = ~q;
      s = {1'b0, p} + {1'b0, q};
      low = {1'b0, p[W-2:0]} + {1'b0, q[W-2:0]};
      cin_msb = low[W-1];
      r = c[1] ? s[W-1:0] : (p & q);
      if (c[0]) r = ~r;
      v = c[1] & (cin_msb ^ s[W]);
      return mk_exp(r, (r == '0), r[W-1], v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   logic [EW-1:0] held;
   bit            hold_pending = 0;

   always @(negedge clk) begin
      logic [EW-1:0] act;
      logic [EW-1:0] e;
      act = actual_word();
      if (!reset_n) begin
         hold_pending = 0;
      end else begin
         if (hold_pending && out_valid) begin
            checks++;
            if (act !== held) begin
               errors++;
               $display("FAIL hold_stable: got %h, want %h", act, held);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got %h, want no pending result", act);
            end else begin
               e = exp_q.pop_front();
               if (act !== e) begin
                  errors++;
                  $display("FAIL result#%0d: got out=%h zr=%b ng=%b ovf=%b, want out=%h zr=%b ng=%b ovf=%b",
                           pops, act[EW-1:3], act[2], act[1], act[0], e[EW-1:3], e[2], e[1], e[0]);
               end
            end
            hold_pending = 0;
         end else if (out_valid) begin
            held = act;
            hold_pending = 1;
         end else begin
            hold_pending = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1. Returns at posedge+1 after the accepting edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] c,
                       input logic [EW-1:0] e, output int stalls);
      bit acc;
      acc = 0;
      stalls = 0;
      x = a; y = b; ctl = c; in_valid = 1'b1;
      while (!acc && stalls < 50) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) exp_q.push_back(e);
         else     stalls++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++; errors++;
         $display("FAIL send_timeout: got in_ready=0 for %0d cycles, want accept", stalls);
      end
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      check(name, exp_q.size(), 0);
   endtask

   bit rand_ready = 0;
   always @(posedge clk) begin
      if (rand_ready) begin
         #2 out_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int st;
      int tot;
      int p0;
      vecs[0]  = '{16'h1234, 16'h9876, 6'b000000, 16'h1034, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{16'h1234, 16'h9876, 6'b000010, 16'hAAAA, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{16'h1234, 16'h9876, 6'b101010, 16'h0000, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{16'h1234, 16'h9876, 6'b111111, 16'h0001, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{16'h1234, 16'h9876, 6'b111010, 16'hFFFF, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{16'h1234, 16'h9876, 6'b001100, 16'h1234, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{16'h1234, 16'h9876, 6'b010011, 16'h79BE, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 1'b0, 1'b1, 1'b1};
      vecs[8]  = '{16'h0001, 16'h0001, 6'b000010, 16'h0002, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{16'h1234, 16'h9876, 6'b000111, 16'h8642, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{16'h8000, 16'h8000, 6'b000010, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{16'hFFFF, 16'h0000, 6'b000000, 16'h0000, 1'b1, 1'b0, 1'b0};

      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      x = '0; y = '0; ctl = '0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_state", 32'(buf_state), 0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", 32'(in_ready), 1);
      check("post_rst_outputs", 32'(actual_word()), 0);

      // table vectors, consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         send(vecs[i].vx, vecs[i].vy, vecs[i].vctl,
              mk_exp(vecs[i].e_out, vecs[i].e_zr, vecs[i].e_ng, vecs[i].e_ovf), st);
         if (i == 0) begin
            check("latency_valid", 32'(out_valid), 1);
            check("latency_out", 32'(out), 32'(vecs[0].e_out));
         end
      end
      wait_empty("table_drain");

      // back-pressure: two accepted, third refused until a slot frees
      out_ready = 1'b0;
      send(16'h0003, 16'h0004, 6'b000010, mk_exp(16'h0007, 1'b0, 1'b0, 1'b0), st);
      send(16'h00F0, 16'h0FF0, 6'b000000, mk_exp(16'h00F0, 1'b0, 1'b0, 1'b0), st);
      x = 16'h0005; y = 16'h0005; ctl = 6'b000010; in_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("full_in_ready", 32'(in_ready), 0);
      end
      check("full_state", 32'(buf_state), 2);
      check("full_out_valid", 32'(out_valid), 1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(16'h0005, 16'h0005, 6'b000010, mk_exp(16'h000A, 1'b0, 1'b0, 1'b0), st);
      check("third_stalls", 32'(st), 1);
      wait_empty("backpressure_drain");

      // streaming: 8 words back to back
      tot = 0;
      p0 = pops;
      for (int i = 0; i < 8; i++) begin
         send(16'(i * 16'h0101), 16'(16'h0010 + i), 6'b000010,
              mk_exp(16'(i * 16'h0101 + 16'h0010 + i), 1'b0, 1'b0, 1'b0), st);
         tot += st;
      end
      check("stream_stalls", 32'(tot), 0);
      @(negedge clk); #1;
      check("stream_pops", 32'(pops - p0), 8);
      wait_empty("stream_drain");

      // random traffic with a random consumer
      rand_ready = 1;
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] a, b;
         logic [5:0]   c;
         a = 16'($urandom_range(0, 16'hFFFF));
         b = 16'($urandom_range(0, 16'hFFFF));
         c = 6'($urandom_range(0, 63));
         send(a, b, c, model(a, b, c), st);
      end
      rand_ready = 0;
      @(posedge clk); #3;
      out_ready = 1'b1;
      wait_empty("random_drain");

      // reset with two entries buffered
      out_ready = 1'b0;
      send(16'h1111, 16'h2222, 6'b000010, mk_exp(16'h3333, 1'b0, 1'b0, 1'b0), st);
      send(16'h4444, 16'h1111, 6'b000010, mk_exp(16'h5555, 1'b0, 1'b0, 1'b0), st);
      check("pre_reset_state", 32'(buf_state), 2);
      #3 reset_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 0);
      check("midrst_in_ready", 32'(in_ready), 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("midrst_cleared", 32'(actual_word()), 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      send(16'h0100, 16'h0023, 6'b000010, mk_exp(16'h0123, 1'b0, 1'b0, 1'b0), st);
      wait_empty("after_reset_drain");
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("idle_out_valid", 32'(out_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by 500000, want finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_stage_16.md
ALU_STAGE_16 -- requirements
Module: alu_stage_16

Interface
REQ-001 Parameter: WIDTH, default 16, datapath width of operands and result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand/control word presented.
REQ-005 in_ready  output  1  stage can accept a word this cycle.
REQ-006 x  input  WIDTH  operand x.
REQ-007 y  input  WIDTH  operand y.
REQ-008 ctl  input  6  {zx,nx,zy,ny,f,no}, Hack ALU control bits, zx = bit 5.
REQ-009 out_valid  output  1  result word available.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 out  output  WIDTH  result.
REQ-012 zr  output  1  result == 0.
REQ-013 ng  output  1  result MSB.
REQ-014 ovf  output  1  signed overflow of add (present only per REQ-030).

Function
REQ-015 Compute per Hack ALU: zx zeroes x, then nx inverts x; zy/ny likewise for y; f=1 gives x+y modulo 2^WIDTH, f=0 gives x AND y (bitwise); no inverts the result.
REQ-016 Input transfer occurs on a rising edge with in_valid && in_ready; output transfer on a rising edge with out_valid && out_ready.
REQ-017 Result, zr, ng (and ovf) are computed combinationally from the accepted word and stored together in a 2-entry result buffer; no combinational path from x/y/ctl to outputs.
REQ-018 Latency: a word accepted at edge N is visible on out/out_valid after edge N when the buffer was empty.
REQ-019 Buffer states: EMPTY, ONE, TWO; in_ready = (state != TWO); out_valid = (state != EMPTY).
REQ-020 Transitions: EMPTY->ONE on input transfer; ONE->TWO on input without output; ONE->EMPTY on output without input; ONE stays ONE on simultaneous input and output; TWO->ONE on output transfer.
REQ-021 In TWO, in_valid is ignored (no transfer); no word shall ever be dropped or duplicated.
REQ-022 Ordering strictly FIFO: results leave in acceptance order.
REQ-023 out/zr/ng/ovf hold stable while out_valid && !out_ready.
REQ-024 in_ready shall not depend combinationally on out_ready (full throughput via 2 entries, not bypass).
REQ-025 Buffer read/write pointers wrap modulo 2.

Reset
REQ-026 While reset_n = 0: state EMPTY, out_valid = 0, in_ready = 0.
REQ-027 After reset_n deasserts, in_ready = 1 from the first edge; out, zr, ng, ovf = 0 until first result.
REQ-028 Reset mid-operation discards all buffered results immediately (asynchronous); no partial word emitted after reset.

Configuration
REQ-029 Macro ALU_STAGE_OVF_EN controls the overflow flag.
REQ-030 Defined: port ovf exists; ovf = 1 iff f = 1 and the pre-inversion sum's sign differs from both (post-zx/nx) x and (post-zy/ny) y signs having equal sign; ovf = 0 when f = 0; stored per entry.
REQ-031 Not defined: ovf port and its storage absent; all other behaviour identical.

Verification
REQ-032 x=0x1234, y=0x9876, ctl=000000, out_ready=1 -> out=0x1034, zr=0, ng=0, one cycle after accept.
REQ-033 x=0x1234, y=0x9876, ctl=000010 -> out=0xAAAA, ng=1, zr=0; ctl=101010 (constant 0) -> out=0x0000, zr=1; ctl=111111 -> out=0x0001.
REQ-034 out_ready=0, three words offered back-to-back -> first two accepted, in_ready=0 on third; then out_ready=1 -> results emitted in order, third accepted next, none lost.
REQ-035 Continuous in_valid=1, out_ready=1 for 8 words -> one result per cycle, in_ready stays 1, order preserved.
REQ-036 ALU_STAGE_OVF_EN defined, x=0x7FFF, y=0x0001, ctl=000010 -> out=0x8000, ovf=1, ng=1; x=0x0001, y=0x0001 -> ovf=0.
REQ-037 Two entries buffered, reset_n pulsed low mid-cycle -> out_valid=0 immediately; after release, first new word yields correct result, old entries never appear.
